// File: rtl/snacq_sequencer_if.sv
// Control bundle between the host/datapath side and the acquisition sequencer.
// The master side issues commands and strobes; the sequencer (slave) drives the datapath controls.
interface snacq_sequencer_if;
    logic        start;
    logic        abort;
    logic [1:0]  mode;
    logic [11:0] n_acqnum;
    logic [15:0] acqnum;
    logic [15:0] rd_words;
    logic        acq_clk;
    logic        rd_strobe;

    logic        noise_load;
    logic        signal_load;
    logic        n_s_ctrl;
    logic        s_acq_en;
    logic        RAM_WT_EN;
    logic        RAM_RD_EN;
    logic        RAM_RDaddr_rst;
    logic        busy;
    logic        done;
    logic        aborted;

    modport master (
        output start, abort, mode, n_acqnum, acqnum, rd_words, acq_clk, rd_strobe,
        input  noise_load, signal_load, n_s_ctrl, s_acq_en, RAM_WT_EN, RAM_RD_EN,
               RAM_RDaddr_rst, busy, done, aborted
    );

    modport slave (
        input  start, abort, mode, n_acqnum, acqnum, rd_words, acq_clk, rd_strobe,
        output noise_load, signal_load, n_s_ctrl, s_acq_en, RAM_WT_EN, RAM_RD_EN,
               RAM_RDaddr_rst, busy, done, aborted
    );
endinterface

// File: rtl/snacq_sequencer.sv
// Acquisition sequencer: optional noise acquire, optional signal acquire, then RAM readout.
// All outputs are registered decodes of the next state, so they switch on the state-change edge.
module snacq_sequencer #(
    parameter int LOAD_CYCLES = 2,
    parameter int SETTLE      = 4
) (
    input  logic              clk_sys,
    input  logic              reset,
    snacq_sequencer_if.slave  bus
);
    localparam logic [3:0] ST_IDLE     = 4'd0;
    localparam logic [3:0] ST_N_LOAD   = 4'd1;
    localparam logic [3:0] ST_N_SETTLE = 4'd2;
    localparam logic [3:0] ST_N_ACQ    = 4'd3;
    localparam logic [3:0] ST_S_LOAD   = 4'd4;
    localparam logic [3:0] ST_S_SETTLE = 4'd5;
    localparam logic [3:0] ST_S_ACQ    = 4'd6;
    localparam logic [3:0] ST_RD_INIT  = 4'd7;
    localparam logic [3:0] ST_READOUT  = 4'd8;
    localparam logic [3:0] ST_DONE     = 4'd9;

    localparam logic [15:0] LOAD_LAST   = 16'(LOAD_CYCLES - 1);
    localparam logic [15:0] SETTLE_LAST = 16'(SETTLE - 1);
    // A zero settle time skips the settle state entirely.
    localparam logic [3:0]  N_AFTER_LOAD = (SETTLE == 0) ? ST_N_ACQ : ST_N_SETTLE;
    localparam logic [3:0]  S_AFTER_LOAD = (SETTLE == 0) ? ST_S_ACQ : ST_S_SETTLE;

    logic [3:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        acq_prev_q;
    logic        sig_en_q, sig_en_d;
    logic [15:0] n_target_q, n_target_d;
    logic [15:0] s_target_q, s_target_d;
    logic [15:0] rd_target_q, rd_target_d;

    logic        noise_load_q, signal_load_q, n_s_ctrl_q, s_acq_en_q;
    logic        wt_en_q, rd_en_q, rdaddr_rst_q, busy_q, done_q, aborted_q;

    logic        acq_edge;
    logic        abort_take;
    logic [15:0] cnt_inc;

    assign acq_edge = bus.acq_clk & ~acq_prev_q;
    assign cnt_inc  = cnt_q + 16'd1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sig_en_d    = sig_en_q;
        n_target_d  = n_target_q;
        s_target_d  = s_target_q;
        rd_target_d = rd_target_q;
        abort_take  = 1'b0;

        // Abort outranks start, sample edges and terminal count.
        if (state_q != ST_IDLE && bus.abort) begin
            state_d    = ST_IDLE;
            cnt_d      = 16'd0;
            abort_take = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && !bus.abort && bus.mode != 2'b00) begin
                        sig_en_d    = bus.mode[1];
                        n_target_d  = {4'd0, bus.n_acqnum};
                        s_target_d  = bus.acqnum;
                        rd_target_d = bus.rd_words;
                        cnt_d       = 16'd0;
                        state_d     = bus.mode[0] ? ST_N_LOAD : ST_S_LOAD;
                    end
                end
                ST_N_LOAD, ST_S_LOAD: begin
                    if (cnt_q == LOAD_LAST) begin
                        cnt_d   = 16'd0;
                        state_d = (state_q == ST_N_LOAD) ? N_AFTER_LOAD : S_AFTER_LOAD;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_N_SETTLE, ST_S_SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d   = 16'd0;
                        state_d = (state_q == ST_N_SETTLE) ? ST_N_ACQ : ST_S_ACQ;
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_N_ACQ: begin
                    if (n_target_q == 16'd0 || (acq_edge && cnt_inc == n_target_q)) begin
                        cnt_d   = 16'd0;
                        state_d = sig_en_q ? ST_S_LOAD : ST_RD_INIT;
                    end else if (acq_edge) begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_S_ACQ: begin
                    if (s_target_q == 16'd0 || (acq_edge && cnt_inc == s_target_q)) begin
                        cnt_d   = 16'd0;
                        state_d = ST_RD_INIT;
                    end else if (acq_edge) begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_RD_INIT: state_d = ST_READOUT;
                ST_READOUT: begin
                    if (rd_target_q == 16'd0 || (bus.rd_strobe && cnt_inc == rd_target_q)) begin
                        cnt_d   = 16'd0;
                        state_d = ST_DONE;
                    end else if (bus.rd_strobe) begin
                        cnt_d = cnt_inc;
                    end
                end
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q       <= ST_IDLE;
            cnt_q         <= 16'd0;
            acq_prev_q    <= 1'b0;
            sig_en_q      <= 1'b0;
            n_target_q    <= 16'd0;
            s_target_q    <= 16'd0;
            rd_target_q   <= 16'd0;
            noise_load_q  <= 1'b0;
            signal_load_q <= 1'b0;
            n_s_ctrl_q    <= 1'b1;
            s_acq_en_q    <= 1'b0;
            wt_en_q       <= 1'b0;
            rd_en_q       <= 1'b0;
            rdaddr_rst_q  <= 1'b1;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            acq_prev_q    <= bus.acq_clk;
            sig_en_q      <= sig_en_d;
            n_target_q    <= n_target_d;
            s_target_q    <= s_target_d;
            rd_target_q   <= rd_target_d;
            noise_load_q  <= (state_d == ST_N_LOAD);
            signal_load_q <= (state_d == ST_S_LOAD);
            n_s_ctrl_q    <= !(state_d inside {ST_S_LOAD, ST_S_SETTLE, ST_S_ACQ});
            s_acq_en_q    <= (state_d == ST_S_ACQ);
            wt_en_q       <= (state_d == ST_N_ACQ) || (state_d == ST_S_ACQ);
            rd_en_q       <= (state_d == ST_READOUT);
            rdaddr_rst_q  <= (state_d != ST_RD_INIT);
            busy_q        <= (state_d != ST_IDLE);
            done_q        <= (state_d == ST_DONE);
            aborted_q     <= abort_take;
        end
    end

    assign bus.noise_load     = noise_load_q;
    assign bus.signal_load    = signal_load_q;
    assign bus.n_s_ctrl       = n_s_ctrl_q;
    assign bus.s_acq_en       = s_acq_en_q;
    assign bus.RAM_WT_EN      = wt_en_q;
    assign bus.RAM_RD_EN      = rd_en_q;
    assign bus.RAM_RDaddr_rst = rdaddr_rst_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.aborted        = aborted_q;
endmodule

// File: doc/snacq_sequencer.md
# snacq_sequencer

Acquisition sequencer for the signal/noise acquisition datapath. On one start command it runs an optional noise acquisition, then an optional signal acquisition, then a RAM readout phase. It drives the datapath's load, select, acquire-enable and RAM enable controls, and counts the datapath's `acq_clk` sample strobes and the host read strobes. It sits between the host command/register block and the acquisition datapath, all on `clk_sys`.

## Interface
Parameters:
- `LOAD_CYCLES`, default 2: width in clocks of the `noise_load` / `signal_load` pulses; legal range 1–15.
- `SETTLE`, default 4: idle clocks after a load pulse before the acquire phase starts; legal range 0–255.

Ports:
- `clk_sys` in 1: system clock. Clock and reset are the only things decided ahead of this spec; everything else is defined here.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle command pulse; accepted only in IDLE.
- `abort` in 1: level or pulse; returns the block to IDLE.
- `mode` in 2: bit0 enables the noise phase, bit1 enables the signal phase; sampled when `start` is accepted.
- `n_acqnum` in 12: number of noise samples; sampled when `start` is accepted.
- `acqnum` in 16: number of signal samples; sampled when `start` is accepted.
- `rd_words` in 16: number of readout words; sampled when `start` is accepted.
- `acq_clk` in 1: sample strobe from the datapath, synchronous to `clk_sys`; rising edges are counted.
- `rd_strobe` in 1: host read strobe; one word is counted per high cycle.
- `noise_load` out 1: noise-parameter load pulse.
- `signal_load` out 1: signal-parameter load pulse.
- `n_s_ctrl` out 1: datapath select; 1 = noise, 0 = signal.
- `s_acq_en` out 1: signal acquisition enable.
- `RAM_WT_EN` out 1: RAM write enable.
- `RAM_RD_EN` out 1: RAM read enable.
- `RAM_RDaddr_rst` out 1: active-low read-address reset.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse on normal completion.
- `aborted` out 1: one-cycle pulse when an abort is taken.

## Operation
- **States:** IDLE, N_LOAD, N_SETTLE, N_ACQ, S_LOAD, S_SETTLE, S_ACQ, RD_INIT, READOUT, DONE.
- **IDLE:**
  - On `start` with `mode != 0`: latch all count inputs, clear counters.
  - Go to N_LOAD if `mode[0]`, otherwise S_LOAD.
  - `start` with `mode == 0` is ignored.
- **N_LOAD:** `n_s_ctrl` = 1, `noise_load` = 1 for `LOAD_CYCLES` clocks, then N_SETTLE.
- **N_SETTLE:** `n_s_ctrl` = 1, hold for `SETTLE` clocks (0 means pass straight through), then N_ACQ.
- **N_ACQ:** `n_s_ctrl` = 1, `RAM_WT_EN` = 1.
  - The sample counter increments on each `acq_clk` rising edge (`acq_clk` = 1 with its previous-cycle value = 0).
  - Leave N_ACQ on the clock where the `n_acqnum`-th edge is detected.
  - Next state is S_LOAD if `mode[1]`, otherwise RD_INIT.
  - If `n_acqnum` = 0, leave after one cycle with `RAM_WT_EN` high for that single cycle only.
- **S_LOAD / S_SETTLE / S_ACQ:** same as the noise phases, with these differences:
  - `n_s_ctrl` = 0 and the load pulse is `signal_load`.
  - In S_ACQ, `s_acq_en` = 1 and `RAM_WT_EN` = 1, and the target is `acqnum`.
  - S_ACQ exits to RD_INIT.
- **RD_INIT:** `RAM_RDaddr_rst` = 0 for exactly 1 clock, then READOUT.
- **READOUT:** `RAM_RD_EN` = 1; count `rd_strobe` high cycles and leave on the `rd_words`-th. If `rd_words` = 0, go to DONE after one cycle.
- **DONE:** `done` = 1 for one clock, then IDLE.
- **Counter:** 16 bits; `n_acqnum` is zero-extended; there is no wrap, because the exit compare precedes any overflow.
- **Abort:**
  - In any non-IDLE state, `abort` moves the block to IDLE on the next edge and pulses `aborted` for 1 clock.
  - All enables drop that same edge.
  - `done` is not pulsed.
  - `abort` while in IDLE does nothing.
- **Simultaneous events:**
  - `abort` wins over `start`, over an edge in the same cycle, and over terminal-count exit.
  - `start` while busy is ignored.

## Timing
- **Reset values:**
  - `RAM_RDaddr_rst` = 1, `n_s_ctrl` = 1.
  - All other outputs = 0; state = IDLE; counters = 0.
- All outputs are registered (Moore): they change on the clock edge of the state change.
- **Start latency:** `start` sampled at edge k gives `busy`, `n_s_ctrl` and `noise_load` high from edge k+1.
- **Acquire entry:** the acquire enable rises `LOAD_CYCLES` + `SETTLE` clocks after the load pulse begins.
- **Acquire exit:** for an `acq_clk` edge detected in the cycle before edge m, the enable drops at edge m. The final write strobe is therefore inside the enable window.
- `done` is asserted 1 clock after the last READOUT cycle.
- `busy` falls on the same edge that `done` falls.

## Test plan
- **Full run:**
  - Stimulus: `mode` = 3, `n_acqnum` = 3, `acqnum` = 5, `rd_words` = 4, `LOAD_CYCLES` = 2, `SETTLE` = 4, `acq_clk` period 6 clocks, `rd_strobe` every 3rd clock.
  - Required: `noise_load` is high for 2 clocks, `RAM_WT_EN` spans exactly 3 `acq_clk` edges, then `signal_load` is high for 2 clocks.
  - Required: `s_acq_en` spans exactly 5 edges, then `RAM_RDaddr_rst` is low for 1 clock, `RAM_RD_EN` covers 4 strobes, and `done` pulses once.
- **Signal only:** `mode` = 2 -> `noise_load` never pulses and `n_s_ctrl` = 0 throughout acquisition.
- **Zero counts:** `n_acqnum` = 0 and `rd_words` = 0 -> `RAM_WT_EN` is high for 1 clock in N_ACQ, READOUT lasts 1 clock, and `done` still pulses.
- **Abort mid-S_ACQ** after 2 of 5 edges -> next edge: `s_acq_en` = 0, `RAM_WT_EN` = 0, `aborted` = 1, `busy` = 0, no `done`. A fresh `start` afterwards completes normally.
- **Simultaneous events:**
  - `start` with `abort` in the same cycle in IDLE -> stays IDLE.
  - `start` during S_ACQ -> ignored and the counts are unchanged.
  - `mode` = 0 `start` -> ignored.
- **Async reset** asserted in READOUT, between clock edges -> outputs go to their reset values immediately (`RAM_RDaddr_rst` = 1, `n_s_ctrl` = 1, all others 0).
